// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the EEPROM follower and its leader:
// protocol state encoding, default device address and ACK levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_ADDR_HI,
        ST_ACK_HI,
        ST_ADDR_LO,
        ST_ACK_LO,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_RD_ACK
    } i2c_state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;
    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;

    // Receive state that follows each follower-driven ACK slot on the write path.
    function automatic i2c_state_t ack_next(input i2c_state_t s);
        case (s)
            ST_DEV_ACK: return ST_ADDR_HI;
            ST_ACK_HI:  return ST_ADDR_LO;
            ST_ACK_LO:  return ST_WR_DATA;
            ST_WR_ACK:  return ST_WR_DATA;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus stability filter for one I2C line; emits the
// filtered level and single-cycle rise/fall pulses aligned with it.
module i2c_line_filter #(
    parameter int FILT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT - 1)) begin
                cnt_q <= '0;
                level <= sync_q[1];
                rise  <= sync_q[1];
                fall  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_follower.sv
// I2C target emulating a 24LC256-style EEPROM over an external synchronous
// byte RAM: page writes, current/random/sequential reads, open-drain SDA.
module i2c_follower
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         ADDR_W   = 15,
    parameter int         PAGE_W   = 6,
    parameter int         FILT     = 4
) (
    input  logic              CLK_50MHz,
    input  logic              RST,
    input  logic              SCL_in,
    input  logic              SDA_in,
    output logic              SDA_oe,
    input  logic              WP,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output i2c_state_t        dbg_state
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .clk(CLK_50MHz), .rst(RST), .raw(SCL_in),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .clk(CLK_50MHz), .rst(RST), .raw(SDA_in),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;

    i2c_state_t        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic [1:0]        load_q, load_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [7:0]        rx_byte;
    logic              byte_done;

    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hi_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            load_q      <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hi_q        <= hi_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            load_q      <= load_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hi_d        = hi_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        load_d      = load_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        rx_byte     = {shift_q[6:0], sda};
        byte_done   = scl_rise && (bit_cnt_q == 4'd7);

        // Bus conditions override whatever the byte engine is doing.
        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_DEV_ADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        case (state_q)
                            ST_DEV_ADDR: begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = ST_DEV_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = rx_byte[0];
                                end else begin
                                    state_d = ST_IDLE;
                                    busy_d  = 1'b0;
                                end
                            end
                            ST_ADDR_HI: begin
                                hi_d    = rx_byte;
                                state_d = ST_ACK_HI;
                            end
                            ST_ADDR_LO: begin
                                ptr_d   = ADDR_W'({hi_q, rx_byte});
                                state_d = ST_ACK_LO;
                            end
                            default: begin
                                mem_wdata_d = rx_byte;
                                mem_addr_d  = ptr_q;
                                mem_we_d    = ~WP;
                                ptr_d       = {ptr_q[ADDR_W-1:PAGE_W],
                                               ptr_q[PAGE_W-1:0] + PAGE_W'(1)};
                                state_d     = ST_WR_ACK;
                            end
                        endcase
                    end
                end
                // First SCL fall pulls the ACK, the second one releases it.
                ST_DEV_ACK, ST_ACK_HI, ST_ACK_LO, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (state_q == ST_DEV_ACK && rw_q) begin
                                state_d = ST_RD_LOAD;
                                load_d  = '0;
                            end
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ack_next(state_q);
                        end
                    end
                end
                // Strobe, let the RAM register its output, then capture.
                ST_RD_LOAD: begin
                    if (load_q == 2'd0) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = ptr_q;
                        load_d     = 2'd1;
                    end else if (load_q == 2'd1) begin
                        load_d = 2'd2;
                    end else begin
                        shift_d   = mem_rdata;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        load_d    = '0;
                        bit_cnt_d = '0;
                        state_d   = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_ACK) begin
                            state_d = ST_RD_LOAD;
                            load_d  = '0;
                        end else begin
                            state_d  = ST_IDLE;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign SDA_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_follower.sv
// Bench for i2c_follower: bus-level leader tasks, a RAM behind the memory
// port, and a scoreboard that pairs every memory strobe with an expected entry.
module tb_i2c_follower;
    import i2c_pkg::*;

    localparam int Q = 15;  // clocks per quarter SCL period

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    // ---------------- DUT and bus ----------------
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic        wp = 1'b0;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    i2c_state_t  dbg_state;

    assign sda_line = sda_drv & ~sda_oe;

    i2c_follower dut (
        .CLK_50MHz(clk),
        .RST(rst),
        .SCL_in(scl_drv),
        .SDA_in(sda_line),
        .SDA_oe(sda_oe),
        .WP(wp),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .dbg_state(dbg_state)
    );

    logic [7:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [22:0] exp_wr_q[$];
    logic [14:0] exp_rd_q[$];
    logic [22:0] mon_wr_e;
    logic [14:0] mon_rd_e;
    logic        oe_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (!rst && mem_we) begin
            if (exp_wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                mon_wr_e = exp_wr_q.pop_front();
                check("mem_we_addr_data", {mem_addr, mem_wdata}, {9'd0, mon_wr_e});
            end
        end
        if (!rst && mem_re) begin
            if (exp_rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_re: got addr %0h expected no read", mem_addr);
            end else begin
                mon_rd_e = exp_rd_q.pop_front();
                check("mem_re_addr", {17'd0, mem_addr}, {17'd0, mon_rd_e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; wait_clk(Q);
            scl_drv = 1'b1; wait_clk(2 * Q);
            scl_drv = 1'b0; wait_clk(Q);
        end
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        ack = sda_line; wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        sda_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            scl_drv = 1'b1; wait_clk(Q);
            b[i] = sda_line; wait_clk(Q);
            scl_drv = 1'b0;
        end
        wait_clk(Q);
        sda_drv = ack; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(2 * Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic send_seq(input string name, input logic [7:0] seq [5], input int n, input logic exp_ack);
        logic a;
        for (int i = 0; i < n; i++) begin
            write_byte(seq[i], a);
            check(name, {31'd0, a}, {31'd0, exp_ack});
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] seq [5];
    logic [7:0] rd;
    logic       ack;

    initial begin
        wait_clk(3);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        rst = 1'b0;
        wait_clk(10);

        // Two-byte write at 0x0123.
        exp_wr_q.push_back({15'h0123, 8'h5A});
        exp_wr_q.push_back({15'h0124, 8'hC3});
        seq = '{8'hA0, 8'h01, 8'h23, 8'h5A, 8'hC3};
        bus_start();
        send_seq("wr_ack", seq, 5, I2C_ACK);
        check("wr_busy_mid", {31'd0, busy}, 32'd1);
        bus_stop();
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        check("wr_state_after_stop", {28'd0, dbg_state}, {28'd0, ST_IDLE});

        // Random read of 0x0123 then sequential 0x0124.
        seq = '{8'hA0, 8'h01, 8'h23, 8'h00, 8'h00};
        bus_start();
        send_seq("rr_addr_ack", seq, 3, I2C_ACK);
        bus_start();
        exp_rd_q.push_back(15'h0123);
        exp_rd_q.push_back(15'h0124);
        write_byte(8'hA1, ack);
        check("rr_dev_ack", {31'd0, ack}, 32'd0);
        read_byte(I2C_ACK, rd);
        check("rr_byte0", {24'd0, rd}, 32'h5A);
        read_byte(I2C_NACK, rd);
        check("rr_byte1", {24'd0, rd}, 32'hC3);
        check("rr_state_after_nack", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        check("rr_busy_after_nack", {31'd0, busy}, 32'd0);
        bus_stop();

        // Page rollover inside the 64-byte page.
        exp_wr_q.push_back({15'h003E, 8'h11});
        exp_wr_q.push_back({15'h003F, 8'h22});
        exp_wr_q.push_back({15'h0000, 8'h33});
        seq = '{8'hA0, 8'h00, 8'h3E, 8'h11, 8'h22};
        bus_start();
        send_seq("pw_ack", seq, 5, I2C_ACK);
        write_byte(8'h33, ack);
        check("pw_ack_last", {31'd0, ack}, 32'd0);
        bus_stop();

        // Wrong device address.
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'hA2, ack);
        check("wa_nack", {31'd0, ack}, 32'd1);
        check("wa_busy", {31'd0, busy}, 32'd0);
        bus_stop();
        check("wa_oe_never", {31'd0, oe_seen}, 32'd0);

        // Write protect: everything ACKed, no write strobes.
        wp = 1'b1;
        seq = '{8'hA0, 8'h01, 8'h23, 8'h5A, 8'hC3};
        bus_start();
        send_seq("wp_ack", seq, 5, I2C_ACK);
        bus_stop();
        wp = 1'b0;

        // Short SDA pulses while SCL high are neither START nor STOP.
        sda_drv = 1'b0; wait_clk(2);
        sda_drv = 1'b1; wait_clk(Q);
        check("gl_no_start", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        bus_start();
        write_byte(8'hA0, ack);
        check("gl_dev_ack", {31'd0, ack}, 32'd0);
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b1; wait_clk(2);
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
        check("gl_no_stop_state", {28'd0, dbg_state}, {28'd0, ST_ADDR_HI});
        check("gl_no_stop_busy", {31'd0, busy}, 32'd1);
        bus_stop();
        check("gl_real_stop", {31'd0, busy}, 32'd0);

        // Reset in the middle of a read of 0x0000 (holds 0x33, MSB 0).
        seq = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00};
        bus_start();
        send_seq("rst_rd_addr_ack", seq, 3, I2C_ACK);
        bus_start();
        exp_rd_q.push_back(15'h0000);
        write_byte(8'hA1, ack);
        check("rst_rd_dev_ack", {31'd0, ack}, 32'd0);
        check("rst_rd_bit7_drive", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_mid_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(5);
        bus_stop();

        wait_clk(50);
        check("wr_queue_empty", exp_wr_q.size(), 32'd0);
        check("rd_queue_empty", exp_rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_follower.md
Name: i2c_follower

Overview:
- I2C target (follower) that emulates a 24LC256-style EEPROM at 50 MHz.
- Decodes the control byte, the 2-byte word address, page writes, and current/random/sequential reads from the bus.
- Data is backed by an external synchronous byte RAM. Used as the bus partner of the EEPROM leader during bring-up and simulation, and as a drop-in EEPROM stand-in on the DE2-115.
- SDA is open-drain: the block only ever pulls low.

Parameters:
- DEV_ADDR, 7'b1010000, 7-bit device address the block acknowledges (1010 + A2A1A0).
- ADDR_W, 15, word-address bits used (32 KiB); upper unused address bits are ignored.
- PAGE_W, 6, page size is 2^PAGE_W bytes; the write pointer wraps inside the page.
- FILT, 4, CLK cycles SCL/SDA must be stable before a filtered level change is accepted.

Ports:
- CLK_50MHz  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- SCL_in  in  1  bus clock, raw pin level
- SDA_in  in  1  bus data, raw pin level
- SDA_oe  out  1  1 = pull SDA low, 0 = release
- WP  in  1  write protect; 1 = ACK data bytes but suppress mem_we
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  8  RAM read data
- busy  out  1  1 from an addressed START to the STOP or NACK that ends the transfer

Behaviour:
- Reset (async assert, sync release): SDA_oe=0, mem_we=0, mem_re=0, busy=0, mem_addr=0, mem_wdata=0, address pointer=0, state=IDLE.
- Input conditioning:
  - 2-FF synchroniser on each line, then a FILT-cycle stability filter.
  - SCL rise/fall and SDA edges are derived from the filtered levels.
- Bus conditions:
  - START = filtered SDA falls while SCL=1. It forces state DEV_ADDR and a bit count of 0 from any state, which covers repeated START.
  - STOP = filtered SDA rises while SCL=1. It forces IDLE, SDA_oe=0, busy=0.
- Bit timing:
  - Sample SDA on the filtered SCL rise.
  - Change SDA_oe only on the filtered SCL fall.
  - MSB first; 8 data bits, then 1 ACK bit.
- States: IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK.
- DEV_ADDR:
  - After 8 bits, compare bits[7:1] with DEV_ADDR.
  - Mismatch -> IDLE, no ACK, busy stays 0.
  - Match -> DEV_ACK; SDA_oe=1 on the next SCL fall and released on the fall after that; busy=1.
  - R/W=0 -> ADDR_HI.
  - R/W=1 -> RD_LOAD.
- ADDR_HI / ADDR_LO:
  - Each byte is always ACKed.
  - The pointer is loaded as {hi,lo}[ADDR_W-1:0] after the low byte.
  - Then -> WR_DATA.
- WR_DATA:
  - Each received byte is ACKed.
  - In the cycle after the 8th SCL rise: mem_wdata=byte, mem_addr=pointer, and mem_we pulses 1 cycle unless WP=1.
  - Pointer low PAGE_W bits increment and wrap (page rollover); upper bits are unchanged.
- RD_LOAD:
  - Pulse mem_re with mem_addr=pointer.
  - Capture mem_rdata one cycle later into the shift register.
  - Pointer increments modulo 2^ADDR_W.
  - Load completes well before the ACK-ending SCL fall, since the minimum SCL low time far exceeds 3 cycles.
- RD_DATA:
  - On each SCL fall drive SDA_oe = ~bit (a 0 bit pulls low).
  - After 8 bits, release SDA and go to RD_ACK.
- RD_ACK:
  - Sample SDA on SCL rise.
  - 0 (leader ACK) -> RD_LOAD for the next byte (sequential read).
  - 1 (NACK) -> IDLE, release, busy=0.
- Current-address read uses the pointer left by the last access. Random read is a write of the address, then repeated START, then a read.
- Write with only address bytes (no data) followed by STOP: pointer updated, no mem_we.
- SDA_oe is never asserted while SCL=1 except during an ACK or data bit the block owns. The block never drives SCL (no clock stretching).

Decomposition:
- Package i2c_pkg: state enum, DEV_ADDR default 7'b1010000, ACK/NACK constants. The leader shares this package.
- Sub-module i2c_line_filter: sync plus glitch filter plus edge pulses; instantiated once per line.

Test Plan:
- Write 0xA0, 0x01, 0x23, 0x5A, 0xC3, STOP -> ACK on all 5 bytes; mem_we at 0x0123=0x5A and 0x0124=0xC3; busy falls at STOP.
- Random read: write 0xA0, 0x01, 0x23, repeated START, 0xA1, leader ACK then NACK, RAM holds 0x5A/0xC3 -> SDA bytes 0x5A, 0xC3; two mem_re pulses at 0x0123 and 0x0124; IDLE after NACK.
- Page wrap: write at 0x003E with 3 data bytes -> mem_we addresses 0x003E, 0x003F, 0x0000.
- Wrong address 0xA2 -> no ACK (SDA_oe stays 0); busy=0; no memory strobes.
- WP=1 with the write from the first scenario -> all bytes ACKed, no mem_we pulses.
- 2-cycle SDA glitch while SCL=1 -> no START/STOP detected; RST asserted mid-read -> SDA_oe=0 immediately and state=IDLE.
